// File: rtl/pio_byte_stream_rx.sv
// pio_byte_stream_rx: turns the toggle-handshaked HPS PIO byte port into a valid/ready byte stream.
module pio_byte_stream_rx #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] pio_data_in,
    input  logic              pio_req_toggle,
    output logic              pio_ack_toggle,
    input  logic              clear_overflow,
    output logic              overflow,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   fifo_level,
    output logic              fifo_full,
    output logic [CNT_W-1:0]  byte_count
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
    typedef enum logic {IDLE, WAIT_SPACE} state_t;
    state_t state, state_nx;
    logic req_q, req_edge, push, pop, ack_nx, load_hold, ovf_set;
    logic [DATA_W-1:0] hold, push_data;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    assign req_edge  = pio_req_toggle ^ req_q;
    assign fifo_full = fifo_level == FULL_LVL;
    assign m_valid   = fifo_level != '0;
    assign m_data    = m_valid ? mem[rd_ptr] : '0;
    assign pop       = m_valid & m_ready;
    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        push_data = pio_data_in;
        ack_nx    = pio_ack_toggle;
        load_hold = 1'b0;
        ovf_set   = 1'b0;
        if (state == IDLE) begin
            if (req_edge && !fifo_full) begin
                push   = 1'b1;
                ack_nx = pio_req_toggle;
            end else if (req_edge) begin
                load_hold = 1'b1;
                state_nx  = WAIT_SPACE;
            end
        end else begin
            // a second request while one is parked has nowhere to go
            ovf_set   = req_edge;
            push_data = hold;
            if (!fifo_full) begin
                push     = 1'b1;
                ack_nx   = req_q;
                state_nx = IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            req_q          <= 1'b0;
            pio_ack_toggle <= 1'b0;
            hold           <= '0;
            fifo_level     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            overflow       <= 1'b0;
            byte_count     <= '0;
        end else begin
            state          <= state_nx;
            req_q          <= pio_req_toggle;
            pio_ack_toggle <= ack_nx;
            if (load_hold) hold <= pio_data_in;
            fifo_level     <= fifo_level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            wr_ptr         <= wr_ptr + ADDR_W'(push);
            rd_ptr         <= rd_ptr + ADDR_W'(pop);
            overflow       <= ovf_set ? 1'b1 : (clear_overflow ? 1'b0 : overflow);
            byte_count     <= byte_count + CNT_W'(push);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_pio_byte_stream_rx.sv
// tb_pio_byte_stream_rx: random and directed stimulus checked against a queue-based model of the byte stream.
module tb_pio_byte_stream_rx;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [7:0] pio_data_in = '0, m_data;
    logic pio_req_toggle = 1'b0, pio_ack_toggle, clear_overflow = 1'b0, overflow;
    logic m_valid, m_ready = 1'b0, fifo_full;
    logic [4:0] fifo_level;
    logic [15:0] byte_count;
    int checks = 0, failures = 0;

    pio_byte_stream_rx dut (
        .clk(clk), .reset_n(reset_n), .pio_data_in(pio_data_in), .pio_req_toggle(pio_req_toggle),
        .pio_ack_toggle(pio_ack_toggle), .clear_overflow(clear_overflow), .overflow(overflow),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
        .fifo_full(fifo_full), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Model: stored bytes as a queue, one parked byte while the FIFO is full
    logic [7:0] mq[$];
    bit mdl_wait, mdl_ack, mdl_ovf, mdl_reqp, mdl_edge, mdl_full, mdl_pop;
    logic [7:0] mdl_hold;
    logic [15:0] mdl_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            mdl_wait = 0; mdl_ack = 0; mdl_ovf = 0; mdl_reqp = 0; mdl_hold = 0; mdl_cnt = 0;
        end else begin
            mdl_edge = pio_req_toggle != mdl_reqp;
            mdl_full = mq.size() == 16;
            mdl_pop  = mq.size() != 0 && m_ready;
            if (mdl_pop) void'(mq.pop_front());
            if (!mdl_wait) begin
                if (mdl_edge && !mdl_full) begin
                    mq.push_back(pio_data_in); mdl_cnt++; mdl_ack = pio_req_toggle;
                end else if (mdl_edge) begin
                    mdl_hold = pio_data_in; mdl_wait = 1;
                end
                if (clear_overflow) mdl_ovf = 0;
            end else begin
                if (mdl_edge) mdl_ovf = 1;
                else if (clear_overflow) mdl_ovf = 0;
                if (!mdl_full) begin
                    mq.push_back(mdl_hold); mdl_cnt++; mdl_ack = mdl_reqp; mdl_wait = 0;
                end
            end
            mdl_reqp = pio_req_toggle;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        chk("m_data", 32'(m_data), mq.size() != 0 ? 32'(mq[0]) : 32'd0);
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("fifo_full", 32'(fifo_full), 32'(mq.size() == 16));
        chk("ack", 32'(pio_ack_toggle), 32'(mdl_ack));
        chk("overflow", 32'(overflow), 32'(mdl_ovf));
        chk("byte_count", 32'(byte_count), 32'(mdl_cnt));
    end

    // drive one cycle's inputs just after a rising edge, then advance past the next one
    task automatic cyc(input bit flip, input logic [7:0] d, input bit rdy, input bit clr);
        pio_data_in = d;
        if (flip) pio_req_toggle = ~pio_req_toggle;
        m_ready = rdy;
        clear_overflow = clr;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        pio_req_toggle = 1'b0; m_ready = 1'b0; clear_overflow = 1'b0;
        #1;
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ack", 32'(pio_ack_toggle), 0);
        chk("rst_count", 32'(byte_count), 0);
        chk("rst_data", 32'(m_data), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bit saw77;
        @(posedge clk); #1;
        do_reset();
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        cyc(1, 8'hA5, 1, 0);
        chk("t1_valid", 32'(m_valid), 1);
        chk("t1_data", 32'(m_data), 32'hA5);
        chk("t1_ack", 32'(pio_ack_toggle), 1);
        chk("t1_count", 32'(byte_count), 1);
        cyc(0, 8'h00, 1, 0);
        chk("t1_drained", 32'(fifo_level), 0);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(i), 0, 0);
            chk("t2_ack_follow", 32'(pio_ack_toggle), 32'(pio_req_toggle));
        end
        chk("t2_full", 32'(fifo_full), 1);
        chk("t2_level", 32'(fifo_level), 16);
        cyc(1, 8'h10, 0, 0);
        chk("t2_ack_hold", 32'(pio_ack_toggle), 1);
        chk("t2_level_hold", 32'(fifo_level), 16);
        cyc(0, 8'h00, 1, 0);
        chk("t2_pop_level", 32'(fifo_level), 15);
        chk("t2_pop_head", 32'(m_data), 32'h01);
        chk("t2_ack_still", 32'(pio_ack_toggle), 1);
        cyc(0, 8'h00, 0, 0);
        chk("t2_refill", 32'(fifo_level), 16);
        chk("t2_ack_flip", 32'(pio_ack_toggle), 0);
        cyc(1, 8'h20, 0, 0);
        cyc(1, 8'h77, 0, 0);
        chk("t3_ovf_set", 32'(overflow), 1);
        cyc(0, 8'h00, 0, 1);
        chk("t3_ovf_clr", 32'(overflow), 0);
        saw77 = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid && m_data == 8'h77) saw77 = 1;
            cyc(0, 8'h00, 1, 0);
        end
        chk("t3_no_77", 32'(saw77), 0);
        chk("t3_empty", 32'(fifo_level), 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'($urandom), 0, 0);
        chk("t4_level5", 32'(fifo_level), 5);
        cyc(1, 8'h5A, 1, 0);
        chk("t4_level_same", 32'(fifo_level), 5);
        for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0);
        for (int i = 0; i < 9; i++) cyc(1, 8'($urandom), 0, 0);
        chk("t5_level9", 32'(fifo_level), 9);
        do_reset();
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
        do_reset();
        for (int i = 0; i < 65539; i++) cyc(1, 8'($urandom), 1, 0);
        chk("t6_count_wrap", 32'(byte_count), 3);
        chk("t6_ovf", 32'(overflow), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
